// File: rtl/ram_arbiter_if.sv
// Requester-side bundle for ram_arbiter: two request/ack ports sharing one RAM.
`timescale 1ns/1ps
interface ram_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  ack0;
  logic [DATA_WIDTH-1:0] rdata0;

  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] rdata1;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output ack0, rdata0, ack1, rdata1
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, rdata0, ack1, rdata1
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter onto a single RAM: IDLE->ACCESS->DONE per transaction, round-robin on contention.
// Define RAM_ARB_FIXED_PRIO_EN to make port 0 always win contention instead.
`timescale 1ns/1ps
module ram_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_arbiter_if.slave          bus_if,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_wr_en_o,
  inout  wire  [DATA_WIDTH-1:0] ram_data_io
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  win;
  logic                  grant;
  logic                  rd_live;

  assign grant = (state_q == IDLE) && (bus_if.req0 || bus_if.req1);

`ifdef RAM_ARB_FIXED_PRIO_EN
  always_comb win = bus_if.req0 ? 1'b0 : 1'b1;
`else
  logic last_q;

  // A lone requester wins outright; only contention consults the pointer.
  always_comb begin
    if (bus_if.req0 && bus_if.req1) win = ~last_q;
    else                            win = bus_if.req1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_q <= 1'b1;
    else if (grant) last_q <= win;
  end
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    ram_addr_d = ram_addr_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d    = ACCESS;
          gnt_d      = win;
          we_d       = win ? bus_if.we1    : bus_if.we0;
          ram_addr_d = win ? bus_if.addr1  : bus_if.addr0;
          wdata_d    = win ? bus_if.wdata1 : bus_if.wdata0;
        end
      end
      ACCESS: state_d = DONE;
      DONE: begin
        state_d = IDLE;
        if (!we_q) begin
          if (gnt_q) rdata1_d = ram_data_io;
          else       rdata0_d = ram_data_io;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      ram_addr_q <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      ram_addr_q <= ram_addr_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign ram_addr_o  = ram_addr_q;
  assign ram_wr_en_o = (state_q == ACCESS) && we_q;
  assign ram_data_io = ram_wr_en_o ? wdata_q : {DATA_WIDTH{1'bz}};

  // Read data is passed straight from the bus while ack is high, then held by the register.
  assign rd_live = (state_q == DONE) && !we_q;

  always_comb begin
    bus_if.ack0   = (state_q == DONE) && !gnt_q;
    bus_if.ack1   = (state_q == DONE) &&  gnt_q;
    bus_if.rdata0 = (rd_live && !gnt_q) ? ram_data_io : rdata0_q;
    bus_if.rdata1 = (rd_live &&  gnt_q) ? ram_data_io : rdata1_q;
  end

endmodule
